// File: rtl/tcp_segment_decoder.sv
// tcp_segment_decoder: parses a TCP segment word stream into header fields, option and payload strobes, and a checksum verdict.
module tcp_segment_decoder #(
  parameter int MAX_OPT_WORDS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] len_in,
  input  logic [31:0] data,
  input  logic        data_av,
  output logic [15:0] src_port,
  output logic [15:0] dest_port,
  output logic [31:0] seq_num,
  output logic [31:0] ack_num,
  output logic [3:0]  data_offset,
  output logic        f_urg,
  output logic        f_ack,
  output logic        f_psh,
  output logic        f_rst,
  output logic        f_syn,
  output logic        f_fin,
  output logic [15:0] window,
  output logic [15:0] checksum_in,
  output logic [15:0] urg_ptr,
  output logic        hdr_valid,
  output logic [31:0] opt_data,
  output logic        opt_valid,
  output logic [31:0] pay_data,
  output logic        pay_valid,
  output logic [15:0] pay_len,
  output logic        checksum_ok,
  output logic        err,
  output logic        fin
);
  localparam int OW = $clog2(MAX_OPT_WORDS + 1);
  typedef enum logic [2:0] {IDLE, HDR, OPTION, DATA, CHECK, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_len;
  logic [2:0]  r_wcnt;
  logic [OW-1:0] r_opt_left;
  logic [14:0] r_pay_left;
  logic [31:0] r_acc;
  logic        r_phase;
  logic        w_accept, w_idle, w_off_bad, w_last;
  logic [3:0]  w_off;
  logic [15:0] w_pay_len;
  logic [14:0] w_pay_words;
  logic [31:0] w_mask, w_word;
  logic [32:0] w_sum;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  always_comb begin
    w_idle      = (r_state == IDLE) || (r_state == DONE);
    w_accept    = data_av && ((r_state == HDR) || (r_state == OPTION) || (r_state == DATA));
    w_off       = data[31:28];
    w_off_bad   = (w_off < 4'd5) || ({10'b0, w_off, 2'b00} > r_len) ||
                  ({28'b0, w_off} > 32'(5 + MAX_OPT_WORDS));
    w_pay_len   = r_len - {10'b0, data_offset, 2'b00};
    w_pay_words = 15'(({1'b0, w_pay_len} + 17'd3) >> 2);
    w_last      = r_pay_left == 15'd1;
    w_mask      = !w_last               ? 32'hFFFFFFFF :
                  pay_len[1:0] == 2'd1  ? 32'hFF000000 :
                  pay_len[1:0] == 2'd2  ? 32'hFFFF0000 :
                  pay_len[1:0] == 2'd3  ? 32'hFFFFFF00 : 32'hFFFFFFFF;
    w_word      = (r_state == DATA) ? (data & w_mask) : data;
    w_sum       = {1'b0, r_acc} + {1'b0, w_word};
    w_f1        = {1'b0, r_acc[31:16]} + {1'b0, r_acc[15:0]};
    w_f2        = w_f1[15:0] + {15'b0, w_f1[16]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (len_in < 16'd20) ? DONE : HDR;
      HDR: begin
        if (data_av && r_wcnt == 3'd3 && w_off_bad) w_next = DONE;
        else if (data_av && r_wcnt == 3'd4)
          w_next = (data_offset > 4'd5) ? OPTION : (w_pay_words != 15'd0) ? DATA : CHECK;
      end
      OPTION: if (data_av && r_opt_left == OW'(1)) w_next = (r_pay_left != 15'd0) ? DATA : CHECK;
      DATA: if (data_av && w_last) w_next = CHECK;
      CHECK: if (r_phase) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_port <= '0; dest_port <= '0; seq_num <= '0; ack_num <= '0;
      data_offset <= '0; f_urg <= 1'b0; f_ack <= 1'b0; f_psh <= 1'b0;
      f_rst <= 1'b0; f_syn <= 1'b0; f_fin <= 1'b0; window <= '0;
      checksum_in <= '0; urg_ptr <= '0; hdr_valid <= 1'b0;
      opt_data <= '0; opt_valid <= 1'b0; pay_data <= '0; pay_valid <= 1'b0;
      pay_len <= '0; checksum_ok <= 1'b0; err <= 1'b0; fin <= 1'b0;
      r_len <= '0; r_wcnt <= '0; r_opt_left <= '0; r_pay_left <= '0;
      r_acc <= '0; r_phase <= 1'b0;
    end else begin
      opt_valid <= 1'b0;
      pay_valid <= 1'b0;
      if (w_idle && start) begin
        hdr_valid   <= 1'b0;
        checksum_ok <= 1'b0;
        fin         <= len_in < 16'd20;
        err         <= len_in < 16'd20;
        r_acc       <= '0;
        r_wcnt      <= '0;
        r_phase     <= 1'b0;
        r_len       <= len_in;
      end
      if (w_accept) r_acc <= w_sum[31:0] + {31'b0, w_sum[32]};
      if (r_state == HDR && data_av) begin
        r_wcnt <= r_wcnt + 3'd1;
        case (r_wcnt)
          3'd0: begin src_port <= data[31:16]; dest_port <= data[15:0]; end
          3'd1: seq_num <= data;
          3'd2: ack_num <= data;
          3'd3: begin
            data_offset <= w_off;
            {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} <= data[21:16];
            window <= data[15:0];
            if (w_off_bad) begin
              err <= 1'b1;
              fin <= 1'b1;
            end
          end
          3'd4: begin
            checksum_in <= data[31:16];
            urg_ptr     <= data[15:0];
            hdr_valid   <= 1'b1;
            pay_len     <= w_pay_len;
            r_pay_left  <= w_pay_words;
            r_opt_left  <= OW'(data_offset - 4'd5);
          end
          default: ;
        endcase
      end
      if (r_state == OPTION && data_av) begin
        opt_data   <= data;
        opt_valid  <= 1'b1;
        r_opt_left <= r_opt_left - OW'(1);
      end
      if (r_state == DATA && data_av) begin
        pay_data   <= w_word;
        pay_valid  <= 1'b1;
        r_pay_left <= r_pay_left - 15'd1;
      end
      // first CHECK cycle folds the sum, second one publishes the verdict
      if (r_state == CHECK && !r_phase) begin
        r_acc   <= {16'h0, w_f2};
        r_phase <= 1'b1;
      end
      if (r_state == CHECK && r_phase) begin
        checksum_ok <= r_acc[15:0] == 16'hFFFF;
        fin         <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tcp_segment_decoder.sv
// tb_tcp_segment_decoder: directed segments with a queue scoreboard for option/payload strobes.
module tb_tcp_segment_decoder;
  logic        clk = 1'b0, reset, start, data_av;
  logic [15:0] len_in;
  logic [31:0] data;
  logic [15:0] src_port, dest_port, window, checksum_in, urg_ptr, pay_len;
  logic [31:0] seq_num, ack_num, opt_data, pay_data;
  logic [3:0]  data_offset;
  logic f_urg, f_ack, f_psh, f_rst, f_syn, f_fin;
  logic hdr_valid, opt_valid, pay_valid, checksum_ok, err, fin;
  int checks = 0, errors = 0, opt_cnt = 0, pay_cnt = 0;
  logic [31:0] seg[$], raw[$], exp_opt[$], exp_pay[$];

  tcp_segment_decoder dut (
    .clk(clk), .reset(reset), .start(start), .len_in(len_in), .data(data), .data_av(data_av),
    .src_port(src_port), .dest_port(dest_port), .seq_num(seq_num), .ack_num(ack_num),
    .data_offset(data_offset), .f_urg(f_urg), .f_ack(f_ack), .f_psh(f_psh), .f_rst(f_rst),
    .f_syn(f_syn), .f_fin(f_fin), .window(window), .checksum_in(checksum_in), .urg_ptr(urg_ptr),
    .hdr_valid(hdr_valid), .opt_data(opt_data), .opt_valid(opt_valid), .pay_data(pay_data),
    .pay_valid(pay_valid), .pay_len(pay_len), .checksum_ok(checksum_ok), .err(err), .fin(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (opt_valid) begin
      opt_cnt++;
      chk("opt_avail", 32'(exp_opt.size() != 0), 32'd1);
      if (exp_opt.size() != 0) chk("opt_data", opt_data, exp_opt.pop_front());
    end
    if (pay_valid) begin
      pay_cnt++;
      chk("pay_avail", 32'(exp_pay.size() != 0), 32'd1);
      if (exp_pay.size() != 0) chk("pay_data", pay_data, exp_pay.pop_front());
    end
  end

  // builds header/options/payload; seg holds the expected (masked) words, raw what is driven
  task automatic build(input logic [15:0] len, input logic [3:0] off, input logic [5:0] fl,
                       input int nopt, input bit flip);
    logic [31:0] w, g, s;
    int npay, nw;
    seg.delete();
    raw.delete();
    seg.push_back({16'h1234, 16'h0050});
    seg.push_back(32'h00000001);
    seg.push_back(32'h00000000);
    seg.push_back({off, 6'b0, fl, 16'hFFFF});
    seg.push_back(32'h00000000);
    for (int i = 0; i < nopt; i++)
      seg.push_back(i == 0 ? 32'h020405B4 : i == 1 ? 32'h01030307 : 32'h01010101);
    for (int i = 0; i < seg.size(); i++) raw.push_back(seg[i]);
    npay = int'(len) - 4 * int'(off);
    if (npay < 0) npay = 0;
    nw = (npay + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      w = 32'hA1B2C3D4 ^ (j * 32'h11111111);
      g = w;
      for (int b = 0; b < 4; b++)
        if (j * 4 + b >= npay) begin
          w[31 - 8 * b -: 8] = 8'h00;
          g[31 - 8 * b -: 8] = 8'hEE;
        end
      seg.push_back(w);
      raw.push_back(g);
    end
    s = 0;
    for (int i = 0; i < seg.size(); i++) s = s + {16'h0, seg[i][31:16]} + {16'h0, seg[i][15:0]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    seg[4][31:16] = ~s[15:0];
    raw[4] = seg[4];
    if (flip) begin
      seg[5 + nopt][0] = ~seg[5 + nopt][0];
      raw[5 + nopt][0] = ~raw[5 + nopt][0];
    end
  endtask

  task automatic start_seg(input logic [15:0] len);
    start = 1'b1;
    len_in = len;
    opt_cnt = 0;
    pay_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_hdr_clr", {31'b0, hdr_valid}, 32'd0);
    chk("start_fin", {31'b0, fin}, {31'b0, len < 16'd20});
  endtask

  task automatic send(input int nwords, input bit gaps, input int nopt);
    for (int i = 0; i < nwords; i++) begin
      data = raw[i];
      data_av = 1'b1;
      if (i >= 5 && i < 5 + nopt) exp_opt.push_back(seg[i]);
      else if (i >= 5 + nopt) exp_pay.push_back(seg[i]);
      @(posedge clk); #1;
      if (gaps && i % 2 == 0 && i < nwords - 1) begin
        data_av = 1'b0;
        data = 32'hDEADBEEF;
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    data_av = 1'b0;
  endtask

  task automatic wait_fin(input int lat);
    int n = 0;
    while (!fin && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fin_latency", 32'(n), 32'(lat));
    chk("fin", {31'b0, fin}, 32'd1);
  endtask

  task automatic result(input bit ok, input bit e, input int nopt, input int npay, input logic [15:0] plen);
    @(posedge clk); #1;
    chk("checksum_ok", {31'b0, checksum_ok}, {31'b0, ok});
    chk("err", {31'b0, err}, {31'b0, e});
    chk("opt_count", 32'(opt_cnt), 32'(nopt));
    chk("pay_count", 32'(pay_cnt), 32'(npay));
    chk("opt_left", 32'(exp_opt.size()), 32'd0);
    chk("pay_left", 32'(exp_pay.size()), 32'd0);
    if (!e) begin
      chk("hdr_valid", {31'b0, hdr_valid}, 32'd1);
      chk("pay_len", {16'b0, pay_len}, {16'b0, plen});
      chk("checksum_in", {16'b0, checksum_in}, {16'b0, seg[4][31:16]});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_av = 1'b0; len_in = '0; data = '0;
    #1;
    chk("rst_fin", {31'b0, fin}, 32'd0);
    chk("rst_hdr", {31'b0, hdr_valid}, 32'd0);
    chk("rst_src", {16'b0, src_port}, 32'd0);
    chk("rst_strobes", {30'b0, opt_valid, pay_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // minimal 20-byte SYN segment
    build(16'd20, 4'd5, 6'b000010, 0, 1'b0);
    start_seg(16'd20);
    send(5, 1'b0, 0);
    wait_fin(2);
    chk("src_port", {16'b0, src_port}, 32'h1234);
    chk("dest_port", {16'b0, dest_port}, 32'h0050);
    chk("seq_num", seq_num, 32'h1);
    chk("ack_num", ack_num, 32'h0);
    chk("flags", {26'b0, f_urg, f_ack, f_psh, f_rst, f_syn, f_fin}, 32'h02);
    chk("window", {16'b0, window}, 32'hFFFF);
    chk("data_offset", {28'b0, data_offset}, 32'd5);
    result(1'b1, 1'b0, 0, 0, 16'd0);
    // two options and 11 payload bytes
    build(16'd39, 4'd7, 6'b011000, 2, 1'b0);
    start_seg(16'd39);
    send(10, 1'b0, 2);
    wait_fin(2);
    chk("flags2", {26'b0, f_urg, f_ack, f_psh, f_rst, f_syn, f_fin}, 32'h18);
    result(1'b1, 1'b0, 2, 3, 16'd11);
    // same segment with a flipped payload bit
    build(16'd39, 4'd7, 6'b011000, 2, 1'b1);
    start_seg(16'd39);
    send(10, 1'b0, 2);
    wait_fin(2);
    result(1'b0, 1'b0, 2, 3, 16'd11);
    // data offset below 5
    build(16'd40, 4'd4, 6'b000010, 0, 1'b0);
    start_seg(16'd40);
    send(4, 1'b0, 0);
    wait_fin(0);
    send(3, 1'b0, 0);
    result(1'b0, 1'b1, 0, 0, 16'd0);
    chk("err_hdr_valid", {31'b0, hdr_valid}, 32'd0);
    // data offset beyond segment length
    build(16'd24, 4'd8, 6'b000010, 0, 1'b0);
    start_seg(16'd24);
    send(4, 1'b0, 0);
    wait_fin(0);
    result(1'b0, 1'b1, 0, 0, 16'd0);
    // length below the minimum header
    start_seg(16'd12);
    chk("short_err", {31'b0, err}, 32'd1);
    chk("short_ok", {31'b0, checksum_ok}, 32'd0);
    // 9-word segment, gap-free then with data_av gaps
    build(16'd34, 4'd5, 6'b010000, 0, 1'b0);
    start_seg(16'd34);
    send(9, 1'b0, 0);
    wait_fin(2);
    result(1'b1, 1'b0, 0, 4, 16'd14);
    start_seg(16'd34);
    send(9, 1'b1, 0);
    wait_fin(2);
    result(1'b1, 1'b0, 0, 4, 16'd14);
    // reset in the DATA state, then a fresh segment
    build(16'd39, 4'd7, 6'b011000, 2, 1'b0);
    start_seg(16'd39);
    send(8, 1'b0, 2);
    reset = 1'b1;
    #1;
    chk("abort_fin", {31'b0, fin}, 32'd0);
    chk("abort_hdr", {31'b0, hdr_valid}, 32'd0);
    chk("abort_pay_len", {16'b0, pay_len}, 32'd0);
    chk("abort_src", {16'b0, src_port}, 32'd0);
    chk("abort_strobes", {30'b0, opt_valid, pay_valid}, 32'd0);
    exp_opt.delete();
    exp_pay.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    build(16'd20, 4'd5, 6'b000010, 0, 1'b0);
    start_seg(16'd20);
    send(5, 1'b0, 0);
    wait_fin(2);
    chk("post_src", {16'b0, src_port}, 32'h1234);
    result(1'b1, 1'b0, 0, 0, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
